// File: rtl/bus_cycle_mem_slave_if.sv
// rtl/bus_cycle_mem_slave_if.sv - local-bus control signals for the bus-cycle memory slave
interface bus_cycle_mem_slave_if #(
  parameter int ADDR_W = 20,
  parameter int NB     = 2
);
  logic [ADDR_W-1:0] Address;
  logic [NB-1:0]     BE_n;
  logic              M_IO;
  logic              CS;
  logic              ALE;
  logic              RD;
  logic              WR;
  logic              READY;
  logic              ERR;

  modport master (
    output Address, BE_n, M_IO, CS, ALE, RD, WR,
    input  READY, ERR
  );

  modport slave (
    input  Address, BE_n, M_IO, CS, ALE, RD, WR,
    output READY, ERR
  );
endinterface

// File: rtl/bus_cycle_mem_slave.sv
// rtl/bus_cycle_mem_slave.sv - T1/T2/T3(Tw)/T4 bus-cycle memory slave with wait states and byte lanes
module bus_cycle_mem_slave #(
  parameter int                ADDR_W      = 20,
  parameter int                DATA_W      = 16,
  parameter int                DEPTH_LOG2  = 10,
  parameter int                WAIT_STATES = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter bit                SPACE       = 1'b0,
  parameter string             INIT_FILE   = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_cycle_mem_slave_if.slave bus,
  inout  wire [DATA_W-1:0]     Data
);
  localparam int         NB     = DATA_W / 8;
  localparam int         LSB    = $clog2(NB);
  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam int         TAG_LO = LSB + DEPTH_LOG2;
  localparam logic [3:0] WS     = 4'(WAIT_STATES);

  typedef enum logic [1:0] {T1, T2, T3, T4} state_t;

  state_t            state, state_nx;
  logic [3:0]        wcnt, wcnt_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [NB-1:0]     be_q, be_nx;
  logic              mio_q, mio_nx;
  logic              op_wr_q, op_wr_nx;
  logic              err_q, err_nx;

  logic [DATA_W-1:0]     mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] idx;
  logic [DATA_W-1:0]     rd_word;
  logic [NB-1:0]         lane_oe;
  logic                  tag_ok;
  logic                  hit;
  logic                  do_write;
  logic                  unused_bits;

  // Window decode compares only the bits above the word index and lane offset.
  generate
    if (TAG_LO < ADDR_W) begin : g_tag
      assign tag_ok = (bus.Address[ADDR_W-1:TAG_LO] == BASE_ADDR[ADDR_W-1:TAG_LO]);
    end else begin : g_notag
      assign tag_ok = 1'b1;
    end
  endgenerate

  assign hit = !bus.CS && (bus.M_IO == !SPACE) && tag_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= T1;
      wcnt    <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      mio_q   <= 1'b0;
      op_wr_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      wcnt    <= wcnt_nx;
      addr_q  <= addr_nx;
      be_q    <= be_nx;
      mio_q   <= mio_nx;
      op_wr_q <= op_wr_nx;
      err_q   <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    addr_nx  = addr_q;
    be_nx    = be_q;
    mio_nx   = mio_q;
    op_wr_nx = op_wr_q;
    err_nx   = 1'b0;
    case (state)
      T1: begin
        if (bus.ALE && hit) begin
          addr_nx  = bus.Address;
          be_nx    = bus.BE_n;
          mio_nx   = bus.M_IO;
          state_nx = T2;
        end
      end
      T2: begin
        if (bus.CS) begin
          state_nx = T1;
        end else if (!bus.RD && !bus.WR) begin
          err_nx   = 1'b1;
          state_nx = T4;
        end else if (!bus.RD) begin
          op_wr_nx = 1'b0;
          wcnt_nx  = WS;
          state_nx = T3;
        end else if (!bus.WR) begin
          op_wr_nx = 1'b1;
          wcnt_nx  = WS;
          state_nx = T3;
        end
      end
      T3: begin
        if (wcnt != 4'd0) begin
          wcnt_nx = wcnt - 4'd1;
        end else begin
          state_nx = T4;
        end
      end
      T4:      state_nx = T1;
      default: state_nx = T1;
    endcase
  end

  assign idx      = addr_q[LSB +: DEPTH_LOG2];
  assign do_write = (state == T3) && (wcnt == 4'd0) && op_wr_q;
  assign rd_word  = mem[idx];

  // Storage has no reset; an async reset leaves state in T1 so no write can fire.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < NB; i++) begin
        if (!be_q[i]) begin
          mem[idx][i*8 +: 8] <= Data[i*8 +: 8];
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < NB; g++) begin : g_lane
      assign lane_oe[g]        = (state == T3) && !op_wr_q && !be_q[g];
      assign Data[g*8 +: 8]    = lane_oe[g] ? rd_word[g*8 +: 8] : 8'bz;
    end
  endgenerate

  assign bus.READY = (state != T3) || (wcnt == 4'd0);
  assign bus.ERR   = err_q;

  assign unused_bits = ^{addr_q, mio_q};
endmodule

// File: tb/tb_bus_cycle_mem_slave.sv
// tb/tb_bus_cycle_mem_slave.sv - directed vector bench for bus_cycle_mem_slave
module tb_bus_cycle_mem_slave;
  logic clk;
  logic rst;

  bus_cycle_mem_slave_if #(.ADDR_W(20), .NB(2)) bus0 ();
  bus_cycle_mem_slave_if #(.ADDR_W(20), .NB(2)) bus1 ();

  logic        tb_oe;
  logic [15:0] tb_wdata;
  wire  [15:0] data_bus;

  assign data_bus = tb_oe ? tb_wdata : 16'hzzzz;

  // The IO-space, zero-wait instance shares the strobes and data bus.
  assign bus1.Address = bus0.Address;
  assign bus1.BE_n    = bus0.BE_n;
  assign bus1.M_IO    = bus0.M_IO;
  assign bus1.CS      = bus0.CS;
  assign bus1.ALE     = bus0.ALE;
  assign bus1.RD      = bus0.RD;
  assign bus1.WR      = bus0.WR;

  bus_cycle_mem_slave #(
    .ADDR_W(20), .DATA_W(16), .DEPTH_LOG2(10), .WAIT_STATES(2),
    .BASE_ADDR(20'h0), .SPACE(1'b0), .INIT_FILE("")
  ) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .Data(data_bus)
  );

  bus_cycle_mem_slave #(
    .ADDR_W(20), .DATA_W(16), .DEPTH_LOG2(10), .WAIT_STATES(0),
    .BASE_ADDR(20'h0), .SPACE(1'b1), .INIT_FILE("")
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .Data(data_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lane_mask(input logic [1:0] oe);
    return {{8{oe[1]}}, {8{oe[0]}}};
  endfunction

  typedef struct {
    bit          wr;
    logic [19:0] addr;
    logic [1:0]  be_n;
    logic [15:0] wdata;
    logic [15:0] exp_data;
    logic [1:0]  exp_oe;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  // Starts and ends at a negedge in T1; samples outputs at negedges only.
  task automatic run_cycle(input bit io, input bit wr, input logic [19:0] addr,
                           input logic [1:0] be, input logic [15:0] wd, input int stall,
                           output logic [15:0] rdata, output logic [1:0] oe3,
                           output int nlow, output logic [1:0] oe4, output logic err4);
    bus0.ALE = 1'b1; bus0.Address = addr; bus0.BE_n = be; bus0.M_IO = !io; bus0.CS = 1'b0;
    @(negedge clk);
    bus0.ALE = 1'b0;
    for (int s = 0; s < stall; s++) begin
      check("stall_ready", 32'(bus0.READY), 32'd1);
      check("stall_oe", 32'(dut0.lane_oe), 32'd0);
      @(negedge clk);
    end
    if (wr) begin
      bus0.WR = 1'b0; tb_wdata = wd; tb_oe = 1'b1;
    end else begin
      bus0.RD = 1'b0;
    end
    nlow = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (io ? bus1.READY : bus0.READY) break;
      nlow++;
    end
    rdata = data_bus;
    oe3   = io ? dut1.lane_oe : dut0.lane_oe;
    @(negedge clk);
    oe4  = io ? dut1.lane_oe : dut0.lane_oe;
    err4 = io ? bus1.ERR : bus0.ERR;
    bus0.RD = 1'b1; bus0.WR = 1'b1; tb_oe = 1'b0;
    @(negedge clk);
  endtask

  task automatic miss_cycle(input string name, input logic [19:0] addr, input logic mio, input logic cs);
    bus0.ALE = 1'b1; bus0.Address = addr; bus0.BE_n = 2'b00; bus0.M_IO = mio; bus0.CS = cs;
    @(negedge clk);
    bus0.ALE = 1'b0; bus0.WR = 1'b0; tb_wdata = 16'h0BAD; tb_oe = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check({name, "_ready"}, 32'(bus0.READY), 32'd1);
      check({name, "_oe"}, 32'(dut0.lane_oe), 32'd0);
    end
    bus0.WR = 1'b1; tb_oe = 1'b0; bus0.CS = 1'b0; bus0.M_IO = 1'b1;
    @(negedge clk);
  endtask

  logic [15:0] rdata;
  logic [1:0]  oe3, oe4;
  logic        err4;
  int          nlow;

  initial begin
    vecs[0]  = '{1'b1, 20'h00010, 2'b00, 16'hBEEF, 16'h0000, 2'b00};
    vecs[1]  = '{1'b0, 20'h00010, 2'b00, 16'h0000, 16'hBEEF, 2'b11};
    vecs[2]  = '{1'b1, 20'h00010, 2'b01, 16'h12AA, 16'h0000, 2'b00};
    vecs[3]  = '{1'b0, 20'h00010, 2'b00, 16'h0000, 16'h12EF, 2'b11};
    vecs[4]  = '{1'b0, 20'h00010, 2'b10, 16'h0000, 16'h00EF, 2'b01};
    vecs[5]  = '{1'b0, 20'h00010, 2'b01, 16'h0000, 16'h1200, 2'b10};
    vecs[6]  = '{1'b1, 20'h00010, 2'b11, 16'hFFFF, 16'h0000, 2'b00};
    vecs[7]  = '{1'b0, 20'h00010, 2'b00, 16'h0000, 16'h12EF, 2'b11};
    vecs[8]  = '{1'b1, 20'h00020, 2'b00, 16'h1234, 16'h0000, 2'b00};
    vecs[9]  = '{1'b1, 20'h007FE, 2'b00, 16'hA5C3, 16'h0000, 2'b00};
    vecs[10] = '{1'b0, 20'h007FE, 2'b00, 16'h0000, 16'hA5C3, 2'b11};
    vecs[11] = '{1'b0, 20'h00020, 2'b00, 16'h0000, 16'h1234, 2'b11};
    vecs[12] = '{1'b1, 20'h00000, 2'b00, 16'h7777, 16'h0000, 2'b00};
    vecs[13] = '{1'b0, 20'h00000, 2'b00, 16'h0000, 16'h7777, 2'b11};

    rst = 1'b1; tb_oe = 1'b0; tb_wdata = 16'h0;
    bus0.Address = '0; bus0.BE_n = 2'b11; bus0.M_IO = 1'b1;
    bus0.CS = 1'b1; bus0.ALE = 1'b0; bus0.RD = 1'b1; bus0.WR = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready0", 32'(bus0.READY), 32'd1);
    check("reset_err0", 32'(bus0.ERR), 32'd0);
    check("reset_oe0", 32'(dut0.lane_oe), 32'd0);
    check("reset_ready1", 32'(bus1.READY), 32'd1);
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      run_cycle(1'b0, vecs[v].wr, vecs[v].addr, vecs[v].be_n, vecs[v].wdata, 0,
                rdata, oe3, nlow, oe4, err4);
      check($sformatf("v%0d_ready_low", v), 32'(nlow), 32'd2);
      check($sformatf("v%0d_oe_t3", v), 32'(oe3), 32'(vecs[v].exp_oe));
      if (!vecs[v].wr)
        check($sformatf("v%0d_rdata", v), 32'(rdata & lane_mask(vecs[v].exp_oe)),
              32'(vecs[v].exp_data & lane_mask(vecs[v].exp_oe)));
      check($sformatf("v%0d_oe_t4", v), 32'(oe4), 32'd0);
      check($sformatf("v%0d_err", v), 32'(err4), 32'd0);
    end

    miss_cycle("miss_window", 20'h00800, 1'b1, 1'b0);
    miss_cycle("miss_io", 20'h00000, 1'b0, 1'b0);
    miss_cycle("miss_cs", 20'h00000, 1'b1, 1'b1);
    run_cycle(1'b0, 1'b0, 20'h00000, 2'b00, 16'h0, 0, rdata, oe3, nlow, oe4, err4);
    check("miss_mem_kept", 32'(rdata), 32'h7777);

    // CS raised in T2 (with RD also low) must abort back to T1.
    bus0.ALE = 1'b1; bus0.Address = 20'h00020; bus0.BE_n = 2'b00; bus0.M_IO = 1'b1; bus0.CS = 1'b0;
    @(negedge clk);
    bus0.ALE = 1'b0; bus0.CS = 1'b1; bus0.RD = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(bus0.READY), 32'd1);
    check("abort_oe", 32'(dut0.lane_oe), 32'd0);
    bus0.CS = 1'b0; bus0.RD = 1'b1;
    @(negedge clk);
    run_cycle(1'b0, 1'b0, 20'h00010, 2'b00, 16'h0, 0, rdata, oe3, nlow, oe4, err4);
    check("abort_next_rdata", 32'(rdata), 32'h12EF);

    run_cycle(1'b0, 1'b0, 20'h00010, 2'b00, 16'h0, 5, rdata, oe3, nlow, oe4, err4);
    check("stall_rdata", 32'(rdata), 32'h12EF);
    check("stall_ready_low", 32'(nlow), 32'd2);

    bus0.ALE = 1'b1; bus0.Address = 20'h00010; bus0.BE_n = 2'b00; bus0.M_IO = 1'b1; bus0.CS = 1'b0;
    @(negedge clk);
    bus0.ALE = 1'b0; bus0.RD = 1'b0; bus0.WR = 1'b0; tb_wdata = 16'hDEAD; tb_oe = 1'b1;
    @(negedge clk);
    check("perr_err", 32'(bus0.ERR), 32'd1);
    check("perr_ready", 32'(bus0.READY), 32'd1);
    check("perr_oe", 32'(dut0.lane_oe), 32'd0);
    bus0.RD = 1'b1; bus0.WR = 1'b1; tb_oe = 1'b0;
    @(negedge clk);
    check("perr_err_clear", 32'(bus0.ERR), 32'd0);
    run_cycle(1'b0, 1'b0, 20'h00010, 2'b00, 16'h0, 0, rdata, oe3, nlow, oe4, err4);
    check("perr_mem_kept", 32'(rdata), 32'h12EF);

    bus0.ALE = 1'b1; bus0.Address = 20'h00020; bus0.BE_n = 2'b00; bus0.M_IO = 1'b1; bus0.CS = 1'b0;
    @(negedge clk);
    bus0.ALE = 1'b0; bus0.WR = 1'b0; tb_wdata = 16'h5555; tb_oe = 1'b1;
    @(negedge clk);
    check("rst_pre_ready", 32'(bus0.READY), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(bus0.READY), 32'd1);
    check("rst_oe", 32'(dut0.lane_oe), 32'd0);
    @(negedge clk);
    bus0.WR = 1'b1; tb_oe = 1'b0; rst = 1'b1;
    @(negedge clk);
    run_cycle(1'b0, 1'b0, 20'h00020, 2'b00, 16'h0, 0, rdata, oe3, nlow, oe4, err4);
    check("rst_mem_kept", 32'(rdata), 32'h1234);
    check("rst_next_ready_low", 32'(nlow), 32'd2);

    run_cycle(1'b1, 1'b1, 20'h00040, 2'b00, 16'h3C3C, 0, rdata, oe3, nlow, oe4, err4);
    check("ws0_wr_ready_low", 32'(nlow), 32'd0);
    run_cycle(1'b1, 1'b0, 20'h00040, 2'b00, 16'h0, 0, rdata, oe3, nlow, oe4, err4);
    check("ws0_rd_ready_low", 32'(nlow), 32'd0);
    check("ws0_rdata", 32'(rdata), 32'h3C3C);
    check("ws0_oe_t3", 32'(oe3), 32'd3);
    check("ws0_oe_t4", 32'(oe4), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
